// File: rtl/px_frame_signature.sv
// Frame signature monitor for the processed-pixel stream.
// Each accepted pixel is folded into a CRC-16/CCITT-FALSE signature and counted.
// When FRAME_PIXELS pixels have arrived the block reports completion and compares
// the signature with a programmed reference. Any pixels that arrive after the frame
// has closed are flagged and counted.
module px_frame_signature #(
   parameter int          MAX_PIXEL_BITS = 8,
   parameter int          FRAME_PIXELS   = 64,
   parameter logic [15:0] CRC_POLY       = 16'h1021,
   parameter logic [15:0] CRC_INIT       = 16'hFFFF
) (
   input  logic                      clk_i,
   input  logic                      nreset_i,
   input  logic                      start_i,
   input  logic                      px_rdy_i,
   input  logic [MAX_PIXEL_BITS-1:0] px_i,
   input  logic [15:0]               expected_sig_i,
   output logic [15:0]               signature_o,
   output logic [15:0]               px_count_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      match_o,
   output logic                      overrun_o,
   output logic [7:0]                extra_px_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Count value held just before the closing pixel of a frame.
   localparam logic [15:0] LAST_COUNT = 16'(FRAME_PIXELS - 1);

   state_t      state_r;
   state_t      state_next_s;
   logic [15:0] sig_r;
   logic [15:0] cnt_r;
   logic        overrun_r;
   logic [7:0]  extra_r;
   logic        busy_s;
   logic        done_s;
   logic [15:0] crc_next_s;
   logic        last_px_s;

   // One byte through the serial CRC, MSB first, unrolled into a single cycle.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
      logic [15:0] crc;
      crc = crc_in;
      for (int i = 7; i >= 0; i--) begin
         crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ data[i]) ? CRC_POLY : 16'h0000);
      end
      return crc;
   endfunction

   assign crc_next_s = crc16_byte(sig_r, px_i);
   assign last_px_s  = (cnt_r == LAST_COUNT);

   // State register; reset returns the monitor to IDLE.
   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic: start always re-arms; the closing pixel ends the frame.
   always_comb begin
      state_next_s = state_r;
      if (start_i) begin
         state_next_s = ST_RUN;
      end else begin
         case (state_r)
            ST_IDLE: state_next_s = ST_IDLE;
            ST_RUN: begin
               if (px_rdy_i && last_px_s) begin
                  state_next_s = ST_DONE;
               end else begin
                  state_next_s = ST_RUN;
               end
            end
            ST_DONE: state_next_s = ST_DONE;
            default: state_next_s = ST_IDLE;
         endcase
      end
   end

   // Status decode from the registered state.
   always_comb begin
      busy_s = 1'b0;
      done_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
         ST_RUN: begin
            busy_s = 1'b1;
            done_s = 1'b0;
         end
         ST_DONE: begin
            busy_s = 1'b0;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
      endcase
   end

   // Signature, pixel count and post-frame overrun tracking; start drops any coincident pixel.
   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         sig_r     <= CRC_INIT;
         cnt_r     <= 16'd0;
         overrun_r <= 1'b0;
         extra_r   <= 8'd0;
      end else if (start_i) begin
         sig_r     <= CRC_INIT;
         cnt_r     <= 16'd0;
         overrun_r <= 1'b0;
         extra_r   <= 8'd0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (px_rdy_i) begin
                  sig_r <= crc_next_s;
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_DONE: begin
               if (px_rdy_i) begin
                  overrun_r <= 1'b1;
                  if (extra_r != 8'hFF) begin
                     extra_r <= extra_r + 8'd1;
                  end
               end
            end
            default: begin
               sig_r <= sig_r;
            end
         endcase
      end
   end

   assign signature_o = sig_r;
   assign px_count_o  = cnt_r;
   assign busy_o      = busy_s;
   assign done_o      = done_s;
   assign overrun_o   = overrun_r;
   assign extra_px_o  = extra_r;
   assign match_o     = done_s && (sig_r == expected_sig_i);

endmodule

// File: doc/px_frame_signature.md
Name: px_frame_signature

Overview:
- Downstream monitor on the processed-pixel stream leaving the gray/sobel pipeline (out_pixel_o / px_rdy_o).
- Folds each accepted pixel into a CRC-16 signature, counts pixels, and flags frame completion.
- Compares the final signature against a programmed expected value and flags pixels arriving after the frame closes.
- Provides on-chip pass/fail checking of a full frame without shifting every pixel back over SPI.

Parameters:
MAX_PIXEL_BITS, 8, pixel width; must be 8 (CRC processes one byte per pixel).
FRAME_PIXELS, 64, pixels per frame; legal range 1..65535.
CRC_POLY, 16'h1021, CRC generator polynomial, MSB-first.
CRC_INIT, 16'hFFFF, CRC preset at reset and at start.

Ports:
clk_i  input  1  system clock.
nreset_i  input  1  reset; synchronous, active-low.
start_i  input  1  single-cycle pulse: clear and arm for a new frame.
px_rdy_i  input  1  pixel-valid strobe, one cycle per pixel.
px_i  input  MAX_PIXEL_BITS  pixel data, sampled when px_rdy_i=1.
expected_sig_i  input  16  reference signature, static while done_o=1.
signature_o  output  16  running/final CRC (registered).
px_count_o  output  16  pixels accepted in the current frame.
busy_o  output  1  high in RUN.
done_o  output  1  high in DONE.
match_o  output  1  done_o && signature_o==expected_sig_i (combinational on registered signature).
overrun_o  output  1  sticky: a pixel arrived in DONE.
extra_px_o  output  8  count of pixels in DONE, saturating at 255.

Behaviour:
- Reset (nreset_i=0 at clk_i edge) has priority over everything.
  - State goes to IDLE.
  - signature_o=CRC_INIT, px_count_o=0, busy_o=0, done_o=0, overrun_o=0, extra_px_o=0.
  - Reset mid-frame discards all progress.
- FSM states: IDLE, RUN, DONE.
  - IDLE: px_rdy_i ignored. start_i -> RUN.
  - RUN: each px_rdy_i updates the CRC and increments px_count_o. The pixel that makes px_count_o reach FRAME_PIXELS moves the FSM to DONE in the same edge. start_i -> RUN with outputs cleared.
  - DONE: signature_o and px_count_o frozen. px_rdy_i sets overrun_o and increments extra_px_o (saturating at 255). start_i -> RUN.
- start_i is accepted in any state.
  - Next cycle: signature_o=CRC_INIT, px_count_o=0, overrun_o=0, extra_px_o=0, busy_o=1, done_o=0.
  - If px_rdy_i is high in the same cycle as start_i, that pixel is dropped (start wins).
- CRC update: CRC-16/CCITT-FALSE, no reflection, no final XOR.
  - Byte fed MSB-first: 8 serial steps unrolled combinationally in one cycle.
  - Per step: crc = {crc[14:0],1'b0} ^ (crc[15]^bit ? CRC_POLY : 0).
- Latency: signature_o and px_count_o reflect a pixel one cycle after its px_rdy_i. done_o rises in the same cycle as the final signature/count.
- Back-to-back px_rdy_i on every cycle is supported with no stalls and no backpressure; this block never throttles upstream.
- px_count_o is 16 bits wide; it never exceeds FRAME_PIXELS, so it cannot wrap.
- match_o is 0 outside DONE, even if signature_o happens to equal expected_sig_i.

Test Plan:
- FRAME_PIXELS=9; reset, start; feed ASCII "123456789" (0x31..0x39) back-to-back -> one cycle after the last pixel: done_o=1, busy_o=0, signature_o=16'h29B1, px_count_o=9. With expected_sig_i=16'h29B1, match_o=1; with 16'h29B0, match_o=0.
- FRAME_PIXELS=1; start, one pixel 0x00 -> signature_o=16'hE1F0, done_o=1. Pixel strobed in IDLE before start -> no change (signature 16'hFFFF, count 0).
- FRAME_PIXELS=64; 64 pixels with random 0-3 idle gaps -> px_count_o steps 1..64, done_o only after the 64th. Signature equals the bench reference model.
- After DONE, 300 extra px_rdy_i pulses -> overrun_o=1, extra_px_o saturates at 255, signature_o and px_count_o unchanged. Then start_i -> overrun_o=0, extra_px_o=0, busy_o=1.
- Mid-frame (count=5), start_i asserted together with px_rdy_i -> that pixel dropped, count=0, signature=16'hFFFF. Re-run "123456789" -> 16'h29B1.
- Mid-frame, nreset_i=0 for one clock -> all outputs at reset values on the next cycle, FSM IDLE. Subsequent px_rdy_i ignored until start_i.
